// File: rtl/dlfloat_host_link_if.sv
// Host-side bundle between the harness logic and dlfloat_host_link.
// Optional macro DLHL_PERF_CNT_EN adds the tx_count/rx_count outputs.
interface dlfloat_host_link_if;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [15:0] tile_data;
    logic [7:0]  byte_in;
    logic        res_valid;
    logic [15:0] res_data;
    logic        busy;
`ifdef DLHL_PERF_CNT_EN
    logic [15:0] tx_count;
    logic [15:0] rx_count;

    modport master (
        output op_valid, op_a, op_b, byte_in,
        input  op_ready, tile_data, res_valid, res_data, busy, tx_count, rx_count
    );
    modport slave (
        input  op_valid, op_a, op_b, byte_in,
        output op_ready, tile_data, res_valid, res_data, busy, tx_count, rx_count
    );
`else
    modport master (
        output op_valid, op_a, op_b, byte_in,
        input  op_ready, tile_data, res_valid, res_data, busy
    );
    modport slave (
        input  op_valid, op_a, op_b, byte_in,
        output op_ready, tile_data, res_valid, res_data, busy
    );
`endif
endinterface

// File: rtl/dlfloat_host_link.sv
// Host-side link for the DLFloat MAC tile.
// TX: operand pairs are queued in a FIFO and driven onto the tile's 16-bit
// input bus, A word in even cycles, B word in odd cycles.
// RX: the tile's alternating MSB/LSB byte stream is rebuilt into 16-bit words.
// Optional macro DLHL_PERF_CNT_EN adds wrapping tx/rx word counters.
//
// state     | meaning
// TX_IDLE   | bus driven to 0, waiting for an even cycle with a queued pair
// TX_SEND_A | head.a on the bus (even cycle)
// TX_SEND_B | head.b on the bus (odd cycle), head already popped
module dlfloat_host_link #(
    parameter int DEPTH   = 4,
    parameter int RX_SKEW = 1
) (
    input  logic               clk,
    input  logic               rst,
    dlfloat_host_link_if.slave host
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int SW = (RX_SKEW > 0) ? $clog2(RX_SKEW + 1) : 1;
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [SW-1:0] SKEW_INIT = SW'(RX_SKEW);

    typedef enum logic [1:0] {TX_IDLE, TX_SEND_A, TX_SEND_B} tx_state_e;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;
    logic [31:0]   head;

    tx_state_e     state_q, state_d;
    logic          tx_phase_q;
    logic [15:0]   tile_q, tile_d;

    logic [SW-1:0] skew_q;
    logic          rx_phase_q;
    logic [7:0]    msb_q;
    logic [15:0]   res_data_q;
    logic          res_valid_q;
    logic          rx_done;

    // ready is judged on the count before any same-edge pop
    assign host.op_ready = (count_q != FULL);
    assign push          = host.op_valid & host.op_ready;
    assign head          = mem_q[rd_ptr_q];

    // FIFO storage; contents are never observed while empty, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {host.op_a, host.op_b};
        end
    end

    // FIFO occupancy after this edge's push/pop
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // TX next state; SEND_A is only entered on an even-cycle edge, so SEND_B
    // always lands on an odd cycle and phase alignment holds by construction
    always_comb begin
        state_d = TX_IDLE;
        tile_d  = '0;
        pop     = 1'b0;
        case (state_q)
            TX_SEND_A: begin
                state_d = TX_SEND_B;
                tile_d  = head[15:0];
                pop     = 1'b1;
            end
            default: begin
                if (tx_phase_q && (count_q != '0)) begin
                    state_d = TX_SEND_A;
                    tile_d  = head[31:16];
                end
            end
        endcase
    end

    // TX state, phase and registered bus word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= TX_IDLE;
            tx_phase_q <= 1'b0;
            tile_q     <= '0;
        end else begin
            state_q    <= state_d;
            tx_phase_q <= ~tx_phase_q;
            tile_q     <= tile_d;
        end
    end

    assign host.tile_data = tile_q;
    assign host.busy      = (count_q != '0) || (state_q != TX_IDLE);

    assign rx_done = (skew_q == '0) && rx_phase_q;

    // RX byte pairing after the start-up skew
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skew_q      <= SKEW_INIT;
            rx_phase_q  <= 1'b0;
            msb_q       <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            res_valid_q <= rx_done;
            if (skew_q != '0) begin
                skew_q <= skew_q - SW'(1);
            end else begin
                rx_phase_q <= ~rx_phase_q;
                if (!rx_phase_q) begin
                    msb_q <= host.byte_in;
                end else begin
                    res_data_q <= {msb_q, host.byte_in};
                end
            end
        end
    end

    assign host.res_valid = res_valid_q;
    assign host.res_data  = res_data_q;

`ifdef DLHL_PERF_CNT_EN
    logic [15:0] tx_count_q, rx_count_q;

    // rx_count moves on the same edge that raises res_valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_count_q <= '0;
            rx_count_q <= '0;
        end else begin
            if (pop)     tx_count_q <= tx_count_q + 16'd1;
            if (rx_done) rx_count_q <= rx_count_q + 16'd1;
        end
    end

    assign host.tx_count = tx_count_q;
    assign host.rx_count = rx_count_q;
`endif
endmodule

// File: tb/tb_dlfloat_host_link.sv
// Bench for dlfloat_host_link: cycle model with an operand scoreboard on the
// TX side and an expected-word queue on the RX side, plus directed checks.
module tb_dlfloat_host_link;
    localparam int DEPTH   = 4;
    localparam int RX_SKEW = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dlfloat_host_link_if hl();

    dlfloat_host_link #(.DEPTH(DEPTH), .RX_SKEW(RX_SKEW)) dut (
        .clk  (clk),
        .rst  (rst),
        .host (hl)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // reference model state
    logic [31:0] sb_q[$];
    logic [15:0] res_q[$];
    int          m_st;
    logic        m_ph;
    logic [15:0] m_td;
    int          m_skew;
    logic        m_rph;
    logic [7:0]  m_msb;
    logic        m_rv;
    logic        m_push;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_q.delete();
            res_q.delete();
            m_st   = 0;
            m_ph   = 1'b0;
            m_td   = '0;
            m_skew = RX_SKEW;
            m_rph  = 1'b0;
            m_msb  = '0;
            m_rv   = 1'b0;
            cyc    = 0;
        end else begin
            m_push = hl.op_valid && (sb_q.size() < DEPTH);
            if (m_st == 1) begin
                m_st = 2;
                m_td = sb_q[0][15:0];
                void'(sb_q.pop_front());
            end else if (m_ph && sb_q.size() > 0) begin
                m_st = 1;
                m_td = sb_q[0][31:16];
            end else begin
                m_st = 0;
                m_td = '0;
            end
            if (m_push) sb_q.push_back({hl.op_a, hl.op_b});
            m_ph = ~m_ph;
            m_rv = (m_skew == 0) && m_rph;
            if (m_skew != 0) begin
                m_skew--;
            end else begin
                if (!m_rph) m_msb = hl.byte_in;
                else        res_q.push_back({m_msb, hl.byte_in});
                m_rph = ~m_rph;
            end
            cyc++;
        end
    end

    logic [15:0] td_hist [64];
    logic        bz_hist [64];
    logic        rv_hist [64];
    logic [15:0] rd_hist [64];

    always @(negedge clk) begin
        if (cyc < 64) begin
            td_hist[cyc] = hl.tile_data;
            bz_hist[cyc] = hl.busy;
            rv_hist[cyc] = hl.res_valid;
            rd_hist[cyc] = hl.res_data;
        end
        if (!rst) begin
            check_val("tile_data", hl.tile_data, m_td);
            check_val("op_ready", hl.op_ready, sb_q.size() != DEPTH);
            check_val("busy", hl.busy, (sb_q.size() != 0) || (m_st != 0));
            check_val("res_valid", hl.res_valid, m_rv);
            if (hl.res_valid) begin
                if (res_q.size() > 0) check_val("res_data", hl.res_data, res_q.pop_front());
                else                  check_val("res_valid_extra", hl.res_valid, 0);
            end
        end
    end

    logic       rx_dir = 1'b0;
    logic [7:0] rx_tab [5] = '{8'hA5, 8'h3F, 8'h80, 8'h12, 8'h34};

    always @(negedge clk) begin
        if (rx_dir && cyc < 5) hl.byte_in = rx_tab[cyc];
        else                   hl.byte_in = 8'($urandom);
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, output int stalls);
        int n = 0;
        hl.op_valid = 1'b1;
        hl.op_a     = a;
        hl.op_b     = b;
        while (!hl.op_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_val("send_timeout", n, 0);
        @(negedge clk);
        hl.op_valid = 1'b0;
        stalls = n;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int stalls;
        hl.op_valid = 1'b0;
        hl.op_a     = '0;
        hl.op_b     = '0;
        hl.byte_in  = '0;

        // values held during reset
        repeat (2) @(negedge clk);
        check_val("rst_op_ready", hl.op_ready, 1);
        check_val("rst_tile_data", hl.tile_data, 0);
        check_val("rst_res_valid", hl.res_valid, 0);
        check_val("rst_res_data", hl.res_data, 0);
        check_val("rst_busy", hl.busy, 0);

        // single pair pushed in cycle 0, directed RX byte stream
        rx_dir = 1'b1;
        rst    = 1'b0;
        send(16'h3E00, 16'h4000, st);
        repeat (6) @(negedge clk);
        rx_dir = 1'b0;
        check_val("single_c1", td_hist[1], 16'h0000);
        check_val("single_a", td_hist[2], 16'h3E00);
        check_val("single_b", td_hist[3], 16'h4000);
        check_val("single_idle", td_hist[4], 16'h0000);
        check_val("single_busy_c3", bz_hist[3], 1);
        check_val("single_busy_c4", bz_hist[4], 0);
        check_val("rx_rv_c2", rv_hist[2], 0);
        check_val("rx_rv_c3", rv_hist[3], 1);
        check_val("rx_rd_c3", rd_hist[3], 16'h3F80);
        check_val("rx_rv_c4", rv_hist[4], 0);
        check_val("rx_rd_hold_c4", rd_hist[4], 16'h3F80);
        check_val("rx_rv_c5", rv_hist[5], 1);
        check_val("rx_rd_c5", rd_hist[5], 16'h1234);

        // passthrough of all-ones / all-zeros inside a stream
        pulse_reset();
        send(16'h1111, 16'h2222, st);
        send(16'hFFFF, 16'h0000, st);
        send(16'h3333, 16'h4444, st);
        repeat (6) @(negedge clk);
        check_val("pt_a0", td_hist[2], 16'h1111);
        check_val("pt_b0", td_hist[3], 16'h2222);
        check_val("pt_ffff", td_hist[4], 16'hFFFF);
        check_val("pt_0000", td_hist[5], 16'h0000);
        check_val("pt_busy_0000", bz_hist[5], 1);
        check_val("pt_a2", td_hist[6], 16'h3333);
        check_val("pt_b2", td_hist[7], 16'h4444);
        check_val("pt_idle", td_hist[8], 16'h0000);

        // back-to-back pairs past FIFO capacity
        pulse_reset();
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            send(16'hA000 | 16'(i), 16'hB000 | 16'(i), st);
            stalls += st;
        end
        repeat (9) @(negedge clk);
        check_val("b2b_stalled", stalls > 0, 1);
        for (int i = 0; i < 8; i++) begin
            check_val("b2b_a", td_hist[2 + 2 * i], 16'hA000 | 16'(i));
            check_val("b2b_b", td_hist[3 + 2 * i], 16'hB000 | 16'(i));
        end
        check_val("b2b_idle", td_hist[18], 16'h0000);

        // reset in mid-cycle with two pairs queued, one on the bus
        pulse_reset();
        send(16'h5555, 16'h6666, st);
        send(16'h7777, 16'h8888, st);
        #2;
        rst = 1'b1;
        #1;
        check_val("mid_rst_op_ready", hl.op_ready, 1);
        check_val("mid_rst_busy", hl.busy, 0);
        check_val("mid_rst_tile_data", hl.tile_data, 0);
        check_val("mid_rst_res_valid", hl.res_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            check_val("post_rst_tile", td_hist[i], 16'h0000);
            check_val("post_rst_busy", bz_hist[i], 0);
        end

`ifdef DLHL_PERF_CNT_EN
        pulse_reset();
        send(16'h0101, 16'h0202, st);
        send(16'h0303, 16'h0404, st);
        send(16'h0505, 16'h0606, st);
        repeat (7) @(negedge clk);
        check_val("perf_tx_count", hl.tx_count, 3);
        check_val("perf_rx_count", hl.rx_count, 4);
        dut.tx_count_q = 16'hFFFF;
        send(16'h0001, 16'h0002, st);
        repeat (3) @(negedge clk);
        check_val("perf_tx_wrap", hl.tx_count, 0);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
